// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for the 8-bit MAC: buffers pairs in a FIFO, streams one pair per cycle,
// and captures each vector's accumulated result with sticky overflow and pair count.
module mac_dot_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_cin,
  output logic             mac_clr,
  input  logic [15:0]      mac_out,
  input  logic             mac_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_ovf,
  output logic [LEN_W-1:0] res_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StClr, StRun, StFlush, StDrain, StHold} state_e;

  state_e state_q, state_d;

  // Entry layout: {last, a, b}
  logic [16:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;
  logic [16:0] head;

  logic [7:0]       mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic             op_vld_q, op_vld_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic [LEN_W-1:0] res_count_q, res_count_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_a, in_b};
    end
  end

  always_comb begin
    state_d     = state_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    op_vld_d    = op_vld_q;
    ovf_d       = ovf_q | (op_vld_q & mac_cout);
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_count_d = res_count_q;
    pop         = 1'b0;
    unique case (state_q)
      StClr: begin
        mac_a_d  = '0;
        mac_b_d  = '0;
        op_vld_d = 1'b0;
        ovf_d    = 1'b0;
        cnt_d    = '0;
        state_d  = StRun;
      end
      StRun: begin
        if (!empty) begin
          pop      = 1'b1;
          mac_a_d  = head[15:8];
          mac_b_d  = head[7:0];
          op_vld_d = 1'b1;
          if (cnt_q != {LEN_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (head[16]) state_d = StFlush;
        end else begin
          // Zero operands keep the accumulator unchanged while starved
          mac_a_d  = '0;
          mac_b_d  = '0;
          op_vld_d = 1'b0;
        end
      end
      StFlush: begin
        mac_a_d  = '0;
        mac_b_d  = '0;
        op_vld_d = 1'b0;
        state_d  = StDrain;
      end
      StDrain: begin
        res_data_d  = mac_out;
        res_count_d = cnt_q;
        res_ovf_d   = ovf_d;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StClr;
        end
      end
      default: state_d = StClr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClr;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      op_vld_q    <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      op_vld_q    <= op_vld_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_count_q <= res_count_d;
    end
  end

  assign in_ready  = !full;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_cin   = 1'b0;
  assign mac_clr   = (state_q == StClr);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC in the loop, vector-level reference model,
// directed and random vectors.
module tb_mac_dot_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 8;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_a, in_b, mac_a, mac_b;
  logic             mac_cin, mac_clr, mac_cout;
  logic [15:0]      mac_out;
  logic             res_valid, res_ready, res_ovf;
  logic [15:0]      res_data;
  logic [LEN_W-1:0] res_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] va[$];
  logic [7:0] vb[$];

  mac_dot_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_cin  (mac_cin),
    .mac_clr  (mac_clr),
    .mac_out  (mac_out),
    .mac_cout (mac_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_ovf  (res_ovf),
    .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: acc += a*b each cycle, cleared by mac_clr
  logic [15:0] acc = 16'd0;
  logic [15:0] prod;
  logic [16:0] sum17;
  assign prod     = 16'(mac_a) * 16'(mac_b);
  assign sum17    = {1'b0, acc} + {1'b0, prod};
  assign mac_out  = acc;
  assign mac_cout = sum17[16];
  always @(posedge clk or posedge mac_clr) begin
    if (mac_clr) acc <= 16'd0;
    else         acc <= sum17[15:0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result of the vector held in va/vb
  function automatic void model(output int sum, output int ovf, output int cnt);
    int unsigned s = 0;
    ovf = 0;
    for (int i = 0; i < va.size(); i++) begin
      s = s + int'(va[i]) * int'(vb[i]);
      if (s >= 65536) begin
        ovf = 1;
        s   = s - 65536;
      end
    end
    sum = int'(s);
    cnt = (va.size() > 255) ? 255 : va.size();
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = l;
    while (!in_ready && t < 50) begin
      cycle();
      t++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    else           cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input int gap_max);
    for (int i = 0; i < va.size(); i++) begin
      push(va[i], vb[i], (i == va.size() - 1));
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) cycle();
    end
  endtask

  task automatic get_result(input string tag, input bit accept);
    int t = 0;
    int sum, ovf, cnt;
    while (!res_valid && t < 60) begin
      cycle();
      t++;
    end
    model(sum, ovf, cnt);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), sum);
    check({tag, "_ovf"}, 32'(res_ovf), ovf);
    check({tag, "_count"}, 32'(res_count), cnt);
    if (accept) begin
      res_ready = 1'b1;
      cycle();
      res_ready = 1'b0;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    logic [7:0] seen[$];

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_mac_clr", 32'(mac_clr), 32'd1);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("mac_cin", 32'(mac_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pair; latency counted with the push cycle as cycle 1
    va = '{8'd3}; vb = '{8'd5};
    push(8'd3, 8'd5, 1'b1);
    lat = 1;
    while (!res_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("single_latency", 32'(lat), 32'd4);
    get_result("single", 1'b1);
    check("clr_pulse_on", 32'(mac_clr), 32'd1);
    cycle();
    check("clr_pulse_off", 32'(mac_clr), 32'd0);

    // Four-pair dot product
    check("pre_vec_mac_a", 32'(mac_a), 32'd0);
    check("pre_vec_mac_b", 32'(mac_b), 32'd0);
    va = '{8'd1, 8'd3, 8'd5, 8'd7}; vb = '{8'd2, 8'd4, 8'd6, 8'd8};
    send_vec(0);
    get_result("dot4", 1'b0);
    check("post_vec_mac_a", 32'(mac_a), 32'd0);
    check("post_vec_mac_b", 32'(mac_b), 32'd0);
    res_ready = 1'b1; cycle(); res_ready = 1'b0;

    // Overflow followed by a clean vector
    va = '{8'd255, 8'd255}; vb = '{8'd255, 8'd255};
    send_vec(0);
    get_result("ovf", 1'b1);
    va = '{8'd2}; vb = '{8'd2};
    send_vec(0);
    get_result("after_ovf", 1'b1);

    // Backpressure: result held while the FIFO fills
    va = '{8'd1}; vb = '{8'd1};
    send_vec(0);
    get_result("bp_first", 1'b0);
    held = res_data;
    for (int i = 1; i <= DEPTH; i++) push(8'(i), 8'(i), (i == DEPTH));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_res_stable", 32'(res_data), 32'(held));
    check("bp_no_pop", 32'(mac_a), 32'd0);
    res_ready = 1'b1; cycle(); res_ready = 1'b0;
    seen.delete();
    repeat (6) begin
      cycle();
      if (mac_a != 8'd0) seen.push_back(mac_a);
    end
    check("bp_drain_count", 32'(seen.size()), DEPTH);
    for (int i = 0; i < seen.size(); i++) check("bp_drain_order", 32'(seen[i]), i + 1);
    va.delete(); vb.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      va.push_back(8'(i));
      vb.push_back(8'(i));
    end
    get_result("bp_queued", 1'b1);

    // Gapped input: accumulator holds across idle cycles
    va = '{8'd10, 8'd20}; vb = '{8'd10, 8'd1};
    push(8'd10, 8'd10, 1'b0);
    cycle(); cycle();
    repeat (3) begin
      check("gap_mac_a", 32'(mac_a), 32'd0);
      check("gap_acc_hold", 32'(mac_out), 32'd100);
      cycle();
    end
    push(8'd20, 8'd1, 1'b1);
    get_result("gapped", 1'b1);

    // Reset in the middle of a vector
    push(8'd9, 8'd9, 1'b0);
    push(8'd7, 8'd7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mac_clr", 32'(mac_clr), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    va = '{8'd4}; vb = '{8'd4};
    send_vec(0);
    get_result("after_rst", 1'b1);

    // Random vectors with random gaps, some biased towards overflow
    for (int v = 0; v < 8; v++) begin
      int len = $urandom_range(8, 1);
      va.delete(); vb.delete();
      for (int i = 0; i < len; i++) begin
        va.push_back(8'((v % 2) ? $urandom_range(255, 180) : $urandom_range(255, 0)));
        vb.push_back(8'((v % 2) ? $urandom_range(255, 180) : $urandom_range(255, 0)));
      end
      send_vec(2);
      get_result("rand", 1'b1);
    end

    // Long vector saturates the pair counter
    va.delete(); vb.delete();
    for (int i = 0; i < 260; i++) begin
      va.push_back(8'($urandom_range(255, 0)));
      vb.push_back(8'($urandom_range(255, 0)));
    end
    send_vec(0);
    get_result("long_sat", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
